obi_multiport_sram_responder: RTL and testbench

- OBI responder (slave) end for the external CPU cluster's instruction and data initiators.
- Serves NPORTS OBI request ports from one single-ported word-addressed memory array.
- Arbitration is round-robin; configurable wait states model slower memory.
- Sits between the per-hart OBI request/response bundles and local program/data storage of the external CPU subsystem.

---
 rtl/obi_multiport_sram_responder.sv | 120 ++++++++++++
 tb/tb_obi_multiport_sram_responder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/obi_multiport_sram_responder.sv
// Multi-port OBI responder: NPORTS initiators share one single-ported word memory via round-robin.
// Per-port packing: obi_req_i = {req, we, be[3:0], addr[31:0], wdata[31:0]}, obi_resp_o = {gnt, rvalid, rdata[31:0]}.
module obi_multiport_sram_responder #(
    parameter int unsigned NPORTS      = 3,
    parameter int unsigned NUM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NPORTS*70-1:0] obi_req_i,
    output logic [NPORTS*34-1:0] obi_resp_o
);
    localparam int unsigned REQ_W = 70;
    localparam int unsigned RSP_W = 34;
    localparam int unsigned AW    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned PW    = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic [NPORTS-1:0] req;
    logic [NPORTS-1:0] we;
    logic [3:0]        be    [NPORTS];
    logic [31:0]       addr  [NPORTS];
    logic [31:0]       wdata [NPORTS];

    logic [PW-1:0]  rr_ptr;
    logic [3:0]     wait_cnt;
    logic           pend_valid;
    logic [PW-1:0]  pend_port;
    logic [31:0]    pend_rdata;
    logic           resp_fire;

    logic           grant;
    logic [PW-1:0]  win;
    int unsigned    cand;

    logic           sel_we;
    logic [3:0]     sel_be;
    logic [31:0]    sel_addr;
    logic [31:0]    sel_wdata;
    logic [32:0]    diff;
    logic           in_range;
    logic [AW-1:0]  word_idx;
    logic           unused_addr_bits;

    logic [31:0]    mem [NUM_WORDS];

    always_comb begin
        for (int unsigned p = 0; p < NPORTS; p++) begin
            {req[p], we[p], be[p], addr[p], wdata[p]} = obi_req_i[p*REQ_W +: REQ_W];
        end
    end

    // Search upward from rr_ptr; only the first requester found wins.
    always_comb begin
        grant = 1'b0;
        win   = '0;
        cand  = 0;
        if (rst_ni && (wait_cnt == 4'd0)) begin
            for (int unsigned i = 0; i < NPORTS; i++) begin
                cand = 32'(rr_ptr) + i;
                if (cand >= NPORTS) cand = cand - NPORTS;
                if (!grant && req[cand]) begin
                    grant = 1'b1;
                    win   = PW'(cand);
                end
            end
        end
    end

    assign sel_we    = we[win];
    assign sel_be    = be[win];
    assign sel_addr  = addr[win];
    assign sel_wdata = wdata[win];

    // A borrow means below BASE_ADDR; any offset bit above the word index means past the end.
    assign diff             = {1'b0, sel_addr} - {1'b0, BASE_ADDR};
    assign in_range         = !diff[32] && (diff[31:AW+2] == '0);
    assign word_idx         = diff[AW+1:2];
    assign unused_addr_bits = ^diff[1:0];

    assign resp_fire = pend_valid && (wait_cnt == 4'd0);

    always_ff @(posedge clk_i) begin
        if (grant && sel_we && in_range) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (sel_be[b]) mem[word_idx][8*b +: 8] <= sel_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr     <= '0;
            wait_cnt   <= '0;
            pend_valid <= 1'b0;
            pend_port  <= '0;
            pend_rdata <= '0;
        end else begin
            if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
            if (resp_fire) pend_valid <= 1'b0;
            // A grant only happens with wait_cnt at zero, so it never races the decrement.
            if (grant) begin
                pend_valid <= 1'b1;
                pend_port  <= win;
                pend_rdata <= (!sel_we && in_range) ? mem[word_idx] : '0;
                wait_cnt   <= 4'(WAIT_STATES);
                rr_ptr     <= (win == PW'(NPORTS - 1)) ? '0 : win + PW'(1);
            end
        end
    end

    always_comb begin
        obi_resp_o = '0;
        for (int unsigned p = 0; p < NPORTS; p++) begin
            obi_resp_o[p*RSP_W + 33] = grant && (win == PW'(p));
            obi_resp_o[p*RSP_W + 32] = resp_fire && (pend_port == PW'(p));
            obi_resp_o[p*RSP_W +: 32] = (resp_fire && (pend_port == PW'(p))) ? pend_rdata : '0;
        end
    end
endmodule

// File: tb/tb_obi_multiport_sram_responder.sv
// Directed bench: three responder instances (0, 1 and 2 wait states) sharing one request bus.
module tb_obi_multiport_sram_responder;
    localparam int NP = 3;
    localparam int NW = 1024;
    localparam int RW = 70;
    localparam int SW = 34;
    localparam logic [31:0] B = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NP*RW-1:0] req_bus;
    logic [NP*SW-1:0] resp0, resp1, resp2;
    logic [NP-1:0] req_m;
    logic          we;
    logic [3:0]    be;
    logic [31:0]   addr, wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_bus = '0;
        for (int p = 0; p < NP; p++) req_bus[p*RW +: RW] = {req_m[p], we, be, addr, wdata};
    end

    obi_multiport_sram_responder #(.NPORTS(NP), .NUM_WORDS(NW), .BASE_ADDR(B), .WAIT_STATES(0))
        dut0 (.clk_i(clk), .rst_ni(rst_n), .obi_req_i(req_bus), .obi_resp_o(resp0));
    obi_multiport_sram_responder #(.NPORTS(NP), .NUM_WORDS(NW), .BASE_ADDR(32'h0), .WAIT_STATES(1))
        dut1 (.clk_i(clk), .rst_ni(rst_n), .obi_req_i(req_bus), .obi_resp_o(resp1));
    obi_multiport_sram_responder #(.NPORTS(NP), .NUM_WORDS(NW), .BASE_ADDR(32'h0), .WAIT_STATES(2))
        dut2 (.clk_i(clk), .rst_ni(rst_n), .obi_req_i(req_bus), .obi_resp_o(resp2));

    function automatic logic [SW-1:0] port_resp(int d, int p);
        logic [NP*SW-1:0] r;
        r = (d == 0) ? resp0 : (d == 1) ? resp1 : resp2;
        return r[p*SW +: SW];
    endfunction

    function automatic logic [NP-1:0] gnt_mask(int d);
        logic [SW-1:0] r;
        logic [NP-1:0] m;
        for (int p = 0; p < NP; p++) begin
            r = port_resp(d, p);
            m[p] = r[33];
        end
        return m;
    endfunction

    function automatic logic [NP-1:0] rv_mask(int d);
        logic [SW-1:0] r;
        logic [NP-1:0] m;
        for (int p = 0; p < NP; p++) begin
            r = port_resp(d, p);
            m[p] = r[32];
        end
        return m;
    endfunction

    function automatic logic [31:0] rdata_of(int d, int p);
        logic [SW-1:0] r;
        r = port_resp(d, p);
        return r[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle at the negedge, compare 1 ns later, advance to the next negedge.
    task automatic step(input int d, input logic [2:0] rq, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] wd, input logic [2:0] eg,
                        input logic [2:0] ev, input logic [31:0] erd, input string tag);
        req_m = rq; we = w; be = b; addr = a; wdata = wd;
        #1;
        check({tag, " gnt"}, 32'(gnt_mask(d)), 32'(eg));
        check({tag, " rvalid"}, 32'(rv_mask(d)), 32'(ev));
        for (int p = 0; p < NP; p++)
            check($sformatf("%s rdata%0d", tag, p), rdata_of(d, p), ev[p] ? erd : 32'h0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_m = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit          rst;
        logic [2:0]  req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  gnt;
        logic [2:0]  rv;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // rst, req, we, be, addr, wdata, gnt, rvalid, rdata  (all on dut0, WAIT_STATES=0)
        vecs.push_back('{0, 3'b001, 1, 4'hF, B + 32'h10, 32'hDEADBEEF, 3'b001, 3'b000, 32'h0});
        vecs.push_back('{0, 3'b001, 0, 4'hF, B + 32'h10, 32'h0,        3'b001, 3'b001, 32'h0});
        vecs.push_back('{0, 3'b000, 0, 4'h0, 32'h0,      32'h0,        3'b000, 3'b001, 32'hDEADBEEF});
        vecs.push_back('{0, 3'b001, 1, 4'h5, B + 32'h10, 32'h11223344, 3'b001, 3'b000, 32'h0});
        vecs.push_back('{0, 3'b001, 0, 4'h0, B + 32'h10, 32'h0,        3'b001, 3'b001, 32'h0});
        vecs.push_back('{0, 3'b000, 0, 4'h0, 32'h0,      32'h0,        3'b000, 3'b001, 32'hDE22BE44});
        vecs.push_back('{1, 3'b111, 0, 4'hF, B + 32'h10, 32'h0,        3'b001, 3'b000, 32'h0});
        vecs.push_back('{0, 3'b111, 0, 4'hF, B + 32'h10, 32'h0,        3'b010, 3'b001, 32'hDE22BE44});
        vecs.push_back('{0, 3'b111, 0, 4'hF, B + 32'h10, 32'h0,        3'b100, 3'b010, 32'hDE22BE44});
        vecs.push_back('{0, 3'b111, 0, 4'hF, B + 32'h10, 32'h0,        3'b001, 3'b100, 32'hDE22BE44});
        vecs.push_back('{0, 3'b111, 0, 4'hF, B + 32'h10, 32'h0,        3'b010, 3'b001, 32'hDE22BE44});
        vecs.push_back('{0, 3'b111, 0, 4'hF, B + 32'h10, 32'h0,        3'b100, 3'b010, 32'hDE22BE44});
        vecs.push_back('{0, 3'b000, 0, 4'h0, 32'h0,      32'h0,        3'b000, 3'b100, 32'hDE22BE44});
        vecs.push_back('{0, 3'b000, 0, 4'h0, 32'h0,      32'h0,        3'b000, 3'b000, 32'h0});
        vecs.push_back('{0, 3'b001, 1, 4'hF, B + 32'hFFC,  32'hCAFEF00D, 3'b001, 3'b000, 32'h0});
        vecs.push_back('{0, 3'b010, 0, 4'hF, B + 32'h1000, 32'h0,        3'b010, 3'b001, 32'h0});
        vecs.push_back('{0, 3'b100, 1, 4'hF, B + 32'h1000, 32'hFFFFFFFF, 3'b100, 3'b010, 32'h0});
        vecs.push_back('{0, 3'b010, 1, 4'hF, 32'h7FFFFFFC, 32'hFFFFFFFF, 3'b010, 3'b100, 32'h0});
        vecs.push_back('{0, 3'b001, 0, 4'hF, B + 32'hFFC,  32'h0,        3'b001, 3'b010, 32'h0});
        vecs.push_back('{0, 3'b000, 0, 4'h0, 32'h0,        32'h0,        3'b000, 3'b001, 32'hCAFEF00D});

        // Reset state with every port requesting: nothing may be granted or returned.
        req_m = '1; we = 1'b0; be = 4'hF; addr = B; wdata = '0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset d%0d gnt", d), 32'(gnt_mask(d)), 32'h0);
            check($sformatf("reset d%0d rvalid", d), 32'(rv_mask(d)), 32'h0);
            check($sformatf("reset d%0d rdata", d), rdata_of(d, 0) | rdata_of(d, 1) | rdata_of(d, 2), 32'h0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            step(0, vecs[i].req, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata,
                 vecs[i].gnt, vecs[i].rv, vecs[i].rdata, $sformatf("v%0d", i));
        end

        // Two wait states: grant at t, rvalid and next grant at t+3, silence in between.
        do_reset();
        step(2, 3'b100, 1, 4'hF, 32'h40, 32'hA5A55A5A, 3'b100, 3'b000, 32'h0, "ws2 wr");
        step(2, 3'b000, 0, 4'h0, 32'h0,  32'h0,        3'b000, 3'b000, 32'h0, "ws2 wr+1");
        step(2, 3'b000, 0, 4'h0, 32'h0,  32'h0,        3'b000, 3'b000, 32'h0, "ws2 wr+2");
        step(2, 3'b011, 0, 4'hF, 32'h40, 32'h0,        3'b001, 3'b100, 32'h0, "ws2 t");
        step(2, 3'b010, 0, 4'hF, 32'h40, 32'h0,        3'b000, 3'b000, 32'h0, "ws2 t+1");
        step(2, 3'b010, 0, 4'hF, 32'h40, 32'h0,        3'b000, 3'b000, 32'h0, "ws2 t+2");
        step(2, 3'b010, 0, 4'hF, 32'h40, 32'h0,        3'b010, 3'b001, 32'hA5A55A5A, "ws2 t+3");
        step(2, 3'b000, 0, 4'h0, 32'h0,  32'h0,        3'b000, 3'b000, 32'h0, "ws2 t+4");
        step(2, 3'b000, 0, 4'h0, 32'h0,  32'h0,        3'b000, 3'b000, 32'h0, "ws2 t+5");
        step(2, 3'b000, 0, 4'h0, 32'h0,  32'h0,        3'b000, 3'b010, 32'hA5A55A5A, "ws2 t+6");

        // Reset right after a read grant (one wait state): the response is lost, rr_ptr returns to 0.
        do_reset();
        step(1, 3'b010, 0, 4'hF, 32'h0, 32'h0, 3'b010, 3'b000, 32'h0, "mid grant");
        rst_n = 1'b0;
        req_m = '0;
        #1;
        check("mid in-reset rvalid", 32'(rv_mask(1)), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++)
            step(1, 3'b000, 0, 4'h0, 32'h0, 32'h0, 3'b000, 3'b000, 32'h0, $sformatf("mid after%0d", c));
        req_m = 3'b111; we = 1'b0; be = 4'hF; addr = 32'h0;
        #1;
        check("mid rr contention gnt", 32'(gnt_mask(1)), 32'h1);
        @(negedge clk);
        req_m = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
